// File: rtl/plic_target_arbiter.sv
// plic_target_arbiter: sequential-scan claim/complete arbiter for one PLIC hart context.
module plic_target_arbiter #(
    parameter int NUM_SRC = 7,
    parameter int PRIO_W  = 3,
    parameter int ID_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        pending,
    input  logic [NUM_SRC-1:0]        enable,
    input  logic [NUM_SRC*PRIO_W-1:0] prio_flat,
    input  logic [PRIO_W-1:0]         threshold,
    input  logic                      claim_req,
    output logic                      claim_valid,
    output logic [ID_W-1:0]           claim_id,
    output logic [NUM_SRC-1:0]        clr_pend,
    input  logic                      complete_req,
    input  logic [ID_W-1:0]           complete_id,
    output logic                      eip,
    output logic [ID_W-1:0]           max_id
);
    typedef enum logic {SCAN, PUBLISH} state_t;
    state_t state, state_n;
    logic [ID_W-1:0] idx, idx_n, best_id, best_id_n, max_id_n;
    logic [PRIO_W-1:0] best_p, best_p_n, cur_p;
    logic eip_n, cur_e, last;
    logic [NUM_SRC-1:0] in_service, claim_mask, comp_mask;

    always_comb begin
        cur_p = '0;
        cur_e = 1'b0;
        claim_mask = '0;
        comp_mask = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (idx == ID_W'(k + 1)) begin
                cur_p = prio_flat[k*PRIO_W +: PRIO_W];
                cur_e = pending[k] & enable[k] & ~in_service[k] & (cur_p != '0);
            end
            claim_mask[k] = claim_req & eip & (max_id == ID_W'(k + 1));
            comp_mask[k] = complete_req & (complete_id == ID_W'(k + 1));
        end
    end

    assign last = (idx == ID_W'(NUM_SRC));

    always_comb begin
        state_n = state;
        idx_n = idx;
        best_p_n = best_p;
        best_id_n = best_id;
        max_id_n = max_id;
        eip_n = eip;
        if (state == SCAN) begin
            // strict compare keeps the earlier (lower) ID on priority ties
            if (cur_e && cur_p > best_p) begin
                best_p_n = cur_p;
                best_id_n = idx;
            end
            state_n = last ? PUBLISH : SCAN;
            idx_n = last ? idx : idx + ID_W'(1);
        end else begin
            max_id_n = best_id;
            eip_n = best_p > threshold;
            best_p_n = '0;
            best_id_n = '0;
            idx_n = ID_W'(1);
            state_n = SCAN;
        end
        // a claim restarts the scan so the just-claimed winner cannot be served twice
        if (claim_req) begin
            eip_n = 1'b0;
            max_id_n = '0;
            best_p_n = '0;
            best_id_n = '0;
            idx_n = ID_W'(1);
            state_n = SCAN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCAN;
            idx <= ID_W'(1);
            best_p <= '0;
            best_id <= '0;
            max_id <= '0;
            eip <= 1'b0;
            in_service <= '0;
            claim_valid <= 1'b0;
            claim_id <= '0;
            clr_pend <= '0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            best_p <= best_p_n;
            best_id <= best_id_n;
            max_id <= max_id_n;
            eip <= eip_n;
            in_service <= (in_service & ~comp_mask) | claim_mask;
            claim_valid <= claim_req;
            clr_pend <= claim_mask;
            if (claim_req)
                claim_id <= eip ? max_id : '0;
        end
    end
endmodule

// File: tb/tb_plic_target_arbiter.sv
// tb_plic_target_arbiter: scoreboard bench for the PLIC target arbiter.
module tb_plic_target_arbiter;
    localparam int N = 7;
    localparam int BUDGET = 2 * (N + 1) + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] pending = '0, enable = '0;
    logic [N*3-1:0] prio_flat = '0;
    logic [2:0] threshold = '0;
    logic claim_req = 1'b0, complete_req = 1'b0;
    logic [2:0] complete_id = '0;
    logic claim_valid, eip;
    logic [2:0] claim_id, max_id;
    logic [N-1:0] clr_pend;

    int checks = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] id;
        logic [N-1:0] clr;
    } exp_t;
    exp_t sb[$];
    exp_t got;

    plic_target_arbiter dut (
        .clk(clk), .rst_n(rst_n), .pending(pending), .enable(enable),
        .prio_flat(prio_flat), .threshold(threshold), .claim_req(claim_req),
        .claim_valid(claim_valid), .claim_id(claim_id), .clr_pend(clr_pend),
        .complete_req(complete_req), .complete_id(complete_id),
        .eip(eip), .max_id(max_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // claim responses are matched in order against expectations pushed at request time
    always @(negedge clk) begin
        if (rst_n) begin
            if (claim_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_claim_valid: got id %0d, none expected", claim_id);
                end else begin
                    got = sb.pop_front();
                    if (claim_id !== got.id || clr_pend !== got.clr) begin
                        fails++;
                        $display("FAIL claim_resp: id %0d clr %b, expected id %0d clr %b",
                                 claim_id, clr_pend, got.id, got.clr);
                    end
                end
            end else begin
                checks++;
                if (clr_pend !== '0) begin
                    fails++;
                    $display("FAIL clr_pend_idle: got %b, expected 0", clr_pend);
                end
            end
        end
    end

    task automatic push_exp(input logic [2:0] id);
        exp_t e;
        e.id = id;
        e.clr = (id == 0) ? '0 : (N'(1) << (id - 1));
        sb.push_back(e);
    endtask

    task automatic set_prio(input int id, input int p);
        prio_flat[(id-1)*3 +: 3] = 3'(p);
    endtask

    task automatic wait_max(input logic [2:0] id, input int budget);
        int n = 0;
        while (max_id !== id && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_eip(input logic v, input int budget);
        int n = 0;
        while (eip !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_claim(input logic [2:0] exp_id);
        @(negedge clk);
        push_exp(exp_id);
        claim_req = 1'b1;
        @(negedge clk);
        claim_req = 1'b0;
    endtask

    task automatic do_complete(input logic [2:0] id);
        @(negedge clk);
        complete_req = 1'b1;
        complete_id = id;
        @(negedge clk);
        complete_req = 1'b0;
        complete_id = '0;
    endtask

    task automatic test_reset;
        wait_cycles(2);
        checks++;
        if (eip !== 1'b0 || max_id !== 3'd0 || claim_valid !== 1'b0 || claim_id !== 3'd0 || clr_pend !== '0) begin
            fails++;
            $display("FAIL reset_values: eip %b max_id %0d cv %b cid %0d clr %b, expected all 0",
                     eip, max_id, claim_valid, claim_id, clr_pend);
        end
        rst_n = 1'b1;
        pending = '1;
        enable = '1;
        for (int i = 1; i <= N; i++) set_prio(i, 1);
        threshold = 3'd0;
        wait_max(3'd1, BUDGET);
        checks++;
        if (max_id !== 3'd1) begin
            fails++;
            $display("FAIL reset_pre_winner: max_id %0d, expected 1", max_id);
        end
        do_claim(3'd1);
        wait_cycles(3);
        checks++;
        if (dut.in_service !== 7'b0000001) begin
            fails++;
            $display("FAIL reset_pre_inservice: got %b, expected 0000001", dut.in_service);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (dut.in_service !== '0 || eip !== 1'b0 || max_id !== 3'd0 || claim_id !== 3'd0 || clr_pend !== '0) begin
            fails++;
            $display("FAIL reset_async: insvc %b eip %b max_id %0d cid %0d clr %b, expected all 0",
                     dut.in_service, eip, max_id, claim_id, clr_pend);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_priority;
        pending = 7'h7F;
        enable = 7'h7F;
        for (int i = 1; i <= N; i++) set_prio(i, 2);
        set_prio(3, 5);
        threshold = 3'd0;
        wait_max(3'd3, 16);
        checks++;
        if (max_id !== 3'd3 || eip !== 1'b1) begin
            fails++;
            $display("FAIL priority_winner: max_id %0d eip %b, expected 3 and 1", max_id, eip);
        end
        do_claim(3'd3);
        do_complete(3'd3);
    endtask

    task automatic test_tie;
        prio_flat = '0;
        set_prio(2, 4);
        set_prio(6, 4);
        threshold = 3'd1;
        wait_max(3'd2, BUDGET);
        checks++;
        if (max_id !== 3'd2) begin
            fails++;
            $display("FAIL tie_low_id: max_id %0d, expected 2", max_id);
        end
        do_claim(3'd2);
        wait_max(3'd6, BUDGET);
        checks++;
        if (max_id !== 3'd6 || eip !== 1'b1) begin
            fails++;
            $display("FAIL tie_masked: max_id %0d eip %b, expected 6 and 1", max_id, eip);
        end
        do_complete(3'd2);
        wait_max(3'd2, BUDGET);
        checks++;
        if (max_id !== 3'd2) begin
            fails++;
            $display("FAIL tie_after_complete: max_id %0d, expected 2", max_id);
        end
    endtask

    task automatic test_threshold;
        logic seen;
        prio_flat = '0;
        set_prio(5, 3);
        pending = 7'b0010000;
        threshold = 3'd3;
        wait_cycles(BUDGET);
        checks++;
        if (eip !== 1'b0 || max_id !== 3'd5) begin
            fails++;
            $display("FAIL thr_equal: eip %b max_id %0d, expected 0 and 5", eip, max_id);
        end
        do_claim(3'd0);
        checks++;
        if (dut.in_service !== '0) begin
            fails++;
            $display("FAIL thr_claim_zero_insvc: got %b, expected 0", dut.in_service);
        end
        threshold = 3'd2;
        wait_eip(1'b1, BUDGET);
        checks++;
        if (eip !== 1'b1 || max_id !== 3'd5) begin
            fails++;
            $display("FAIL thr_below: eip %b max_id %0d, expected 1 and 5", eip, max_id);
        end
        threshold = 3'd0;
        set_prio(5, 0);
        wait_cycles(BUDGET);
        seen = 1'b0;
        for (int i = 0; i < 2 * BUDGET; i++) begin
            seen |= eip;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL prio_zero: eip seen %b, expected 0", seen);
        end
    endtask

    task automatic test_claim_complete;
        prio_flat = '0;
        set_prio(4, 6);
        pending = 7'b0001000;
        wait_max(3'd4, BUDGET);
        checks++;
        if (max_id !== 3'd4 || eip !== 1'b1) begin
            fails++;
            $display("FAIL cc_setup: max_id %0d eip %b, expected 4 and 1", max_id, eip);
        end
        do_claim(3'd4);
        checks++;
        if (dut.in_service !== 7'b0001000) begin
            fails++;
            $display("FAIL cc_insvc_set: got %b, expected 0001000", dut.in_service);
        end
        do_complete(3'd4);
        wait_max(3'd4, BUDGET);
        @(negedge clk);
        push_exp(3'd4);
        claim_req = 1'b1;
        complete_req = 1'b1;
        complete_id = 3'd4;
        @(negedge clk);
        claim_req = 1'b0;
        complete_req = 1'b0;
        complete_id = '0;
        checks++;
        if (dut.in_service !== 7'b0001000) begin
            fails++;
            $display("FAIL cc_same_edge: in_service %b, expected 0001000", dut.in_service);
        end
    endtask

    task automatic test_bogus_complete;
        logic [2:0] ids [3] = '{3'd0, 3'd7, 3'd2};
        set_prio(1, 2);
        pending = 7'b0001001;
        wait_max(3'd1, BUDGET);
        checks++;
        if (max_id !== 3'd1 || eip !== 1'b1) begin
            fails++;
            $display("FAIL bogus_setup: max_id %0d eip %b, expected 1 and 1", max_id, eip);
        end
        foreach (ids[i]) begin
            do_complete(ids[i]);
            wait_cycles(BUDGET);
            checks++;
            if (dut.in_service !== 7'b0001000 || eip !== 1'b1 || max_id !== 3'd1) begin
                fails++;
                $display("FAIL bogus_complete_%0d: insvc %b eip %b max_id %0d, expected 0001000 1 1",
                         ids[i], dut.in_service, eip, max_id);
            end
        end
        do_complete(3'd4);
        checks++;
        if (dut.in_service !== '0) begin
            fails++;
            $display("FAIL bogus_real_complete: in_service %b, expected 0", dut.in_service);
        end
    endtask

    task automatic test_back_to_back;
        pending = 7'b0000001;
        wait_max(3'd1, BUDGET);
        @(negedge clk);
        push_exp(3'd1);
        push_exp(3'd0);
        claim_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        claim_req = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.in_service !== 7'b0000001) begin
            fails++;
            $display("FAIL b2b_insvc: got %b, expected 0000001", dut.in_service);
        end
        do_complete(3'd1);
    endtask

    initial begin
        test_reset;
        test_priority;
        test_tie;
        test_threshold;
        test_claim_complete;
        test_bogus_complete;
        test_back_to_back;
        wait_cycles(2);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL claims_outstanding: %0d responses missing, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
